// File: rtl/os_training_scheduler_pkg.sv
// rtl/os_training_scheduler_pkg.sv - shared symbols for the lane-training ordered-set scheduler
// Purpose: ordered-set type codes, FSM state encoding, generation codes and
//          SLOS block geometry shared by the scheduler, its interface and bench.
// Ports:   none (package).
package os_training_scheduler_pkg;

   typedef enum logic [2:0] {
      OS_NONE  = 3'd0,
      OS_SLOS1 = 3'd1,
      OS_SLOS2 = 3'd2,
      OS_TS1   = 3'd3,
      OS_TS2   = 3'd4
   } os_type_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SLOS1 = 3'd1,
      ST_SLOS2 = 3'd2,
      ST_TS1   = 3'd3,
      ST_TS2   = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERROR = 3'd6
   } state_e;

   localparam logic [1:0] GEN2 = 2'b01;
   localparam logic [1:0] GEN3 = 2'b10;

   localparam int SLOS_BLOCKS_GEN2 = 32;
   localparam int SLOS_BLOCKS_GEN3 = 16;

   // Index of the final block of one SLOS sequence for the latched generation.
   function automatic logic [4:0] last_block_idx(input logic [1:0] gen);
      return (gen == GEN3) ? 5'(SLOS_BLOCKS_GEN3 - 1) : 5'(SLOS_BLOCKS_GEN2 - 1);
   endfunction

endpackage

// File: rtl/os_training_scheduler_if.sv
// rtl/os_training_scheduler_if.sv - ordered-set request handshake between scheduler and generator
// Purpose: bundles the valid/ready ordered-set request channel.
// Ports:   os_valid     request valid (scheduler -> generator)
//          os_ready     request accepted (generator -> scheduler)
//          os_type      ordered set to emit
//          os_block_idx SLOS block index, 0 for TS
interface os_training_scheduler_if;
   import os_training_scheduler_pkg::*;

   logic       os_valid;
   logic       os_ready;
   os_type_e   os_type;
   logic [4:0] os_block_idx;

   modport master (output os_valid, output os_type, output os_block_idx, input os_ready);
   modport slave  (input os_valid, input os_type, input os_block_idx, output os_ready);

endinterface

// File: rtl/os_training_scheduler_training_timer.sv
// rtl/os_training_scheduler_training_timer.sv - per-state watchdog counter
// Purpose: counts enabled cycles since the last clear and flags the cycle on
//          which the count reaches TIMEOUT_CYC.
// Ports:   clk, rst  clock, synchronous active-high reset
//          clr       restart the count (state change)
//          en        count this cycle
//          expired   this cycle completes TIMEOUT_CYC counted cycles
module training_timer
   #(parameter int               TMR_W       = 20,
     parameter logic [TMR_W-1:0] TIMEOUT_CYC = 20'hFFFFF)
   (input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired);

   localparam logic [TMR_W-1:0] LAST_CNT = TIMEOUT_CYC - TMR_W'(1);

   logic [TMR_W-1:0] cnt;

   // The count after this cycle's increment would equal TIMEOUT_CYC.
   assign expired = en && (cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + TMR_W'(1);
      end
   end

endmodule

// File: rtl/os_training_scheduler.sv
// rtl/os_training_scheduler.sv - SLOS1/SLOS2/TS1/TS2 lane-training ordered-set sequencer
// Purpose: tells the ordered-set generator which set and SLOS block to send,
//          advancing on partner detection, minimum counts and a watchdog.
// Ports:   clk, rst        clock, synchronous active-high reset
//          training_en     level request; low aborts to IDLE
//          gen_sel         01 = Gen2, 10 = Gen3, latched when leaving IDLE
//          rx_slos1_det    partner SLOS1 detected pulse
//          rx_slos2_det    partner SLOS2 detected pulse
//          rx_ts2_det      partner TS2 detected pulse
//          os              ordered-set request channel (master side)
//          training_done   training complete
//          training_err    watchdog timeout or illegal gen_sel
module os_training_scheduler
   import os_training_scheduler_pkg::*;
   #(parameter int               MIN_SLOS    = 2,
     parameter int               TS1_CNT     = 16,
     parameter int               TS2_CNT     = 16,
     parameter int               TMR_W       = 20,
     parameter logic [TMR_W-1:0] TIMEOUT_CYC = 20'hFFFFF)
   (input  logic                            clk,
    input  logic                            rst,
    input  logic                            training_en,
    input  logic [1:0]                      gen_sel,
    input  logic                            rx_slos1_det,
    input  logic                            rx_slos2_det,
    input  logic                            rx_ts2_det,
    os_training_scheduler_if.master         os,
    output logic                            training_done,
    output logic                            training_err);

   localparam logic [7:0]  SEQ_MIN = 8'(MIN_SLOS);
   localparam logic [15:0] TS1_LIM = 16'(TS1_CNT);
   localparam logic [15:0] TS2_LIM = 16'(TS2_CNT);

   state_e      state, state_nxt;
   logic [1:0]  gen_q;
   logic [4:0]  blk_idx;
   logic [7:0]  seq_cnt;
   logic [15:0] ts_cnt;
   logic        slos1_seen, slos2_seen, ts2_seen;

   logic        active, xfer, last_blk, tmr_expired, slos_ok;
   logic        s1_eff, s2_eff, ts2_eff;
   logic [7:0]  seq_wrap;
   logic [15:0] ts_inc, ts_sat;

   always_comb begin
      active   = (state == ST_SLOS1) || (state == ST_SLOS2) ||
                 (state == ST_TS1)   || (state == ST_TS2);
      xfer     = active && os.os_ready;
      last_blk = (blk_idx == last_block_idx(gen_q));
      // Completed-sequence count as it will be after this cycle's wrap.
      seq_wrap = seq_cnt;
      if (last_blk && (seq_cnt < SEQ_MIN)) begin
         seq_wrap = seq_cnt + 8'd1;
      end
      ts_inc   = ts_cnt + 16'd1;
      ts_sat   = (ts_cnt >= TS2_LIM) ? ts_cnt : ts_inc;
      // Sticky flags merged with this cycle's pulse so a coincident pulse counts.
      s1_eff   = slos1_seen || (rx_slos1_det && (state == ST_SLOS1));
      s2_eff   = slos2_seen || (rx_slos2_det &&
                                ((state == ST_SLOS1) || (state == ST_SLOS2)));
      ts2_eff  = ts2_seen   || (rx_ts2_det &&
                                ((state == ST_TS1) || (state == ST_TS2)));
      slos_ok  = xfer && last_blk && (seq_wrap >= SEQ_MIN);
   end

   training_timer #(.TMR_W(TMR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_nxt != state),
      .en      (active),
      .expired (tmr_expired)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort outranks every other event.
   always_comb begin
      state_nxt = state;
      if (!training_en) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  state_nxt = ((gen_sel == GEN2) || (gen_sel == GEN3)) ? ST_SLOS1 : ST_ERROR;
            ST_SLOS1: begin
               if (tmr_expired)                       state_nxt = ST_ERROR;
               else if (slos_ok && (s1_eff || s2_eff)) state_nxt = ST_SLOS2;
            end
            ST_SLOS2: begin
               if (tmr_expired)             state_nxt = ST_ERROR;
               else if (slos_ok && s2_eff)  state_nxt = ST_TS1;
            end
            ST_TS1: begin
               if (tmr_expired)                    state_nxt = ST_ERROR;
               else if (xfer && (ts_inc == TS1_LIM)) state_nxt = ST_TS2;
            end
            ST_TS2: begin
               if (tmr_expired)                                  state_nxt = ST_ERROR;
               else if (xfer && (ts_sat >= TS2_LIM) && ts2_eff)  state_nxt = ST_DONE;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // Counters, latched generation and sticky partner flags.
   always_ff @(posedge clk) begin
      if (rst || (state_nxt == ST_IDLE)) begin
         gen_q      <= 2'b00;
         blk_idx    <= 5'd0;
         seq_cnt    <= 8'd0;
         ts_cnt     <= 16'd0;
         slos1_seen <= 1'b0;
         slos2_seen <= 1'b0;
         ts2_seen   <= 1'b0;
      end else begin
         if (state == ST_IDLE) begin
            gen_q <= gen_sel;
         end
         slos1_seen <= s1_eff;
         slos2_seen <= s2_eff;
         ts2_seen   <= ts2_eff;
         if (state_nxt != state) begin
            blk_idx <= 5'd0;
            seq_cnt <= 8'd0;
            ts_cnt  <= 16'd0;
         end else if (xfer) begin
            case (state)
               ST_SLOS1, ST_SLOS2: begin
                  blk_idx <= last_blk ? 5'd0 : blk_idx + 5'd1;
                  seq_cnt <= seq_wrap;
               end
               ST_TS1:  ts_cnt <= ts_inc;
               ST_TS2:  ts_cnt <= ts_sat;
               default: ts_cnt <= ts_cnt;
            endcase
         end
      end
   end

   // Outputs decode the registered state and counters only.
   always_comb begin
      os.os_valid     = active;
      os.os_type      = OS_NONE;
      os.os_block_idx = 5'd0;
      training_done   = (state == ST_DONE);
      training_err    = (state == ST_ERROR);
      case (state)
         ST_SLOS1: begin os.os_type = OS_SLOS1; os.os_block_idx = blk_idx; end
         ST_SLOS2: begin os.os_type = OS_SLOS2; os.os_block_idx = blk_idx; end
         ST_TS1:   os.os_type = OS_TS1;
         ST_TS2:   os.os_type = OS_TS2;
         default:  os.os_type = OS_NONE;
      endcase
   end

endmodule

// File: tb/tb_os_training_scheduler.sv
// tb/tb_os_training_scheduler.sv - self-checking bench for os_training_scheduler
module tb_os_training_scheduler;
   import os_training_scheduler_pkg::*;

   localparam int MIN_S = 2;
   localparam int TS1_N = 16;
   localparam int TS2_N = 16;

   logic       clk = 1'b0;
   logic       rst, training_en, ready;
   logic [1:0] gen_sel;
   logic       rx_slos1_det, rx_slos2_det, rx_ts2_det;
   logic       done_a, err_a, done_b, err_b;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   os_training_scheduler_if ifa();
   os_training_scheduler_if ifb();
   assign ifa.os_ready = ready;
   assign ifb.os_ready = ready;

   os_training_scheduler dut (
      .clk(clk), .rst(rst), .training_en(training_en), .gen_sel(gen_sel),
      .rx_slos1_det(rx_slos1_det), .rx_slos2_det(rx_slos2_det), .rx_ts2_det(rx_ts2_det),
      .os(ifa.master), .training_done(done_a), .training_err(err_a));

   os_training_scheduler #(.TIMEOUT_CYC(20'd100)) dut_to (
      .clk(clk), .rst(rst), .training_en(training_en), .gen_sel(gen_sel),
      .rx_slos1_det(rx_slos1_det), .rx_slos2_det(rx_slos2_det), .rx_ts2_det(rx_ts2_det),
      .os(ifb.master), .training_done(done_b), .training_err(err_b));

   function automatic logic [10:0] out_a();
      return {ifa.os_valid, ifa.os_type, ifa.os_block_idx, done_a, err_a};
   endfunction

   function automatic logic [10:0] out_b();
      return {ifb.os_valid, ifb.os_type, ifb.os_block_idx, done_b, err_b};
   endfunction

   task automatic test_reset();
      rst = 1'b1; training_en = 1'b0; gen_sel = 2'b00; ready = 1'b0;
      rx_slos1_det = 1'b0; rx_slos2_det = 1'b0; rx_ts2_det = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_a() !== 11'd0) begin
         n_bad++; $display("FAIL reset_a got %b want %b", out_a(), 11'd0);
      end
      n_cmp++;
      if (out_b() !== 11'd0) begin
         n_bad++; $display("FAIL reset_b got %b want %b", out_b(), 11'd0);
      end
      rst = 1'b0;
   endtask

   // Cycle-level reference: phase 0..6 = idle,slos1,slos2,ts1,ts2,done,error;
   // n = transfers accepted so far in the current phase.
   task automatic run_flow(input string name, input logic [1:0] gen, input int rmode,
                           input int s1_at, input int s2_at, input int ts2_after,
                           input int abort_at, input int e1, input int e2, input int e3,
                           input int e4, input int exp_end);
      int phase = 0, n = 0, cyc = 0, hold = 0, blocks, end_phase = -1;
      int cnt[5];
      bit s1 = 0, s2 = 0, s3 = 0, fired = 0, dropped = 0, fin = 0;
      bit en_v, r, p1, p2, p3;
      logic [10:0] exp_v;
      cnt = '{default: 0};
      blocks = (gen == 2'b10) ? 16 : 32;
      @(negedge clk);
      while (!fin && cyc < 3000) begin
         exp_v = {1'(phase >= 1 && phase <= 4),
                  3'((phase >= 1 && phase <= 4) ? phase : 0),
                  5'((phase == 1 || phase == 2) ? n % blocks : 0),
                  1'(phase == 5), 1'(phase == 6)};
         n_cmp++;
         if (out_a() !== exp_v) begin
            n_bad++;
            $display("FAIL %s cyc=%0d outputs{valid,type,idx,done,err} got %b want %b",
                     name, cyc, out_a(), exp_v);
         end
         if (dropped) begin
            fin = 1;
            break;
         end
         en_v = 1'b1;
         if (phase == 5 || phase == 6) begin
            hold++;
            if (hold > 3) en_v = 1'b0;
         end
         r  = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : ($urandom_range(0, 99) < 60);
         p1 = (cyc == s1_at) || (rmode == 2 && $urandom_range(0, 19) == 0);
         p2 = (cyc == s2_at) || (rmode == 2 && $urandom_range(0, 19) == 0);
         p3 = !fired && ((ts2_after >= 0 && phase == 4 && n >= ts2_after) ||
                         (ts2_after == -2 && phase == 3));
         if (p3) fired = 1;
         if (abort_at >= 0 && phase == 3 && n >= abort_at) begin
            en_v = 1'b0; r = 1'b0;
         end
         training_en = en_v; gen_sel = gen; ready = r;
         rx_slos1_det = p1; rx_slos2_det = p2; rx_ts2_det = p3;
         if (!en_v) begin
            if (end_phase < 0) end_phase = phase;
            phase = 0; n = 0; s1 = 0; s2 = 0; s3 = 0; dropped = 1;
         end else if (phase == 0) begin
            phase = (gen == 2'b01 || gen == 2'b10) ? 1 : 6;
         end else begin
            if (p1 && phase == 1) s1 = 1;
            if (p2 && (phase == 1 || phase == 2)) s2 = 1;
            if (p3 && (phase == 3 || phase == 4)) s3 = 1;
            if (phase >= 1 && phase <= 4 && r) begin
               cnt[phase]++;
               n++;
               case (phase)
                  1: if (n % blocks == 0 && n / blocks >= MIN_S && (s1 || s2)) begin phase = 2; n = 0; end
                  2: if (n % blocks == 0 && n / blocks >= MIN_S && s2) begin phase = 3; n = 0; end
                  3: if (n == TS1_N) begin phase = 4; n = 0; end
                  default: if (n >= TS2_N && s3) begin phase = 5; n = 0; end
               endcase
            end
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      rx_slos1_det = 1'b0; rx_slos2_det = 1'b0; rx_ts2_det = 1'b0;
      training_en = 1'b0; ready = 1'b0;
      n_cmp++;
      if (!fin) begin
         n_bad++; $display("FAIL %s cycle budget expired got phase %0d want finished", name, phase);
         repeat (2) @(posedge clk);
      end
      n_cmp++;
      if (cnt[1] !== e1 || cnt[2] !== e2 || cnt[3] !== e3 || cnt[4] !== e4) begin
         n_bad++;
         $display("FAIL %s transfer counts got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                  name, cnt[1], cnt[2], cnt[3], cnt[4], e1, e2, e3, e4);
      end
      n_cmp++;
      if (end_phase !== exp_end) begin
         n_bad++; $display("FAIL %s end phase got %0d want %0d", name, end_phase, exp_end);
      end
   endtask

   task automatic test_flows();
      run_flow("gen2_basic",  2'b01, 0, 5, 70, 0,  -1, 64, 64, 16, 16, 5);
      run_flow("gen3_early",  2'b10, 0, 1, 2,  -2, -1, 32, 32, 16, 16, 5);
      run_flow("gen2_stall",  2'b01, 1, 3, 4,  0,  -1, 64, 64, 16, 16, 5);
      run_flow("ts2_late",    2'b10, 0, 2, 3,  40, -1, 32, 32, 16, 41, 5);
      run_flow("ts2_on_16th", 2'b10, 0, 2, 3,  15, -1, 32, 32, 16, 16, 5);
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         logic [1:0] g;
         int ta, b;
         g  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         ta = $urandom_range(0, 30);
         b  = (g == 2'b10) ? 16 : 32;
         run_flow("random", g, 2, 2, 3, ta, -1, 2 * b, 2 * b, 16, (ta + 1 > 16) ? ta + 1 : 16, 5);
      end
   endtask

   task automatic test_abort_and_illegal();
      run_flow("abort_ts1",   2'b01, 0, 2, 3, 0, 5, 64, 64, 5, 0, 3);
      run_flow("illegal_11",  2'b11, 0, -1, -1, -1, -1, 0, 0, 0, 0, 6);
      run_flow("illegal_00",  2'b00, 0, -1, -1, -1, -1, 0, 0, 0, 0, 6);
   endtask

   task automatic test_timeout();
      logic [10:0] exp_v;
      @(negedge clk);
      gen_sel = 2'b01; training_en = 1'b1; ready = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 100; k++) begin
         @(negedge clk);
         exp_v = (k < 100) ? {1'b1, 3'd1, 5'(k % 32), 1'b0, 1'b0} : 11'b0_000_00000_0_1;
         n_cmp++;
         if (out_b() !== exp_v) begin
            n_bad++; $display("FAIL timeout k=%0d got %b want %b", k, out_b(), exp_v);
         end
         @(posedge clk);
      end
      @(negedge clk);
      training_en = 1'b0; ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_b() !== 11'd0) begin
         n_bad++; $display("FAIL timeout_clear got %b want %b", out_b(), 11'd0);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      gen_sel = 2'b10; training_en = 1'b1; ready = 1'b1; rx_slos1_det = 1'b1;
      @(negedge clk);
      rx_slos1_det = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_a() !== 11'd0) begin
         n_bad++; $display("FAIL reset_mid got %b want %b", out_a(), 11'd0);
      end
      training_en = 1'b0; ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_a() !== 11'd0) begin
         n_bad++; $display("FAIL reset_mid_idle got %b want %b", out_a(), 11'd0);
      end
   endtask

   initial begin
      test_reset();
      test_flows();
      test_random();
      test_abort_and_illegal();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/os_training_scheduler.md
Name: os_training_scheduler

Overview:
- Sequences transmission of lane-training ordered sets: SLOS1 → SLOS2 → TS1 → TS2 for Gen 2/Gen 3 links.
- Sits between the logical-layer link-training control and the ordered-set/PRBS generator.
- Tells the generator which ordered set to emit next and which SLOS block index to use, via a valid/ready handshake.
- Advances on partner-detection pulses from the receive side, minimum transmit counts and a watchdog timeout.

Parameters:
- MIN_SLOS, 2: minimum complete SLOS1 and SLOS2 sequences sent before leaving each SLOS state.
- TS1_CNT, 16: number of TS1 ordered sets sent.
- TS2_CNT, 16: minimum number of TS2 ordered sets sent.
- TMR_W, 20: watchdog counter width.
- TIMEOUT_CYC, 20'hFFFFF: per-state watchdog limit in clk cycles.

Ports:
- clk  in  1  block clock.
- rst  in  1  synchronous, active-high reset.
- training_en  in  1  level; high requests training, low aborts to IDLE.
- gen_sel  in  2  2'b01 = Gen2 (SLOS 64-bit blocks, 32 per sequence), 2'b10 = Gen3 (128-bit blocks, 16 per sequence); sampled on leaving IDLE.
- rx_slos1_det  in  1  one-cycle pulse: partner SLOS1 detected.
- rx_slos2_det  in  1  one-cycle pulse: partner SLOS2 detected.
- rx_ts2_det  in  1  one-cycle pulse: partner TS2 detected.
- os_ready  in  1  generator accepts the current ordered set.
- os_valid  out  1  ordered-set request valid.
- os_type  out  3  OS_NONE = 0, OS_SLOS1 = 1, OS_SLOS2 = 2, OS_TS1 = 3, OS_TS2 = 4.
- os_block_idx  out  5  SLOS block index (0..BLOCKS-1); 0 for TS.
- training_done  out  1  training complete.
- training_err  out  1  watchdog timeout or illegal gen_sel.

Behaviour:
- Reset values: os_valid = 0, os_type = OS_NONE, os_block_idx = 0, training_done = 0, training_err = 0. All internal counters and sticky flags are 0. State is IDLE.
- States: IDLE, SLOS1, SLOS2, TS1, TS2, DONE, ERROR.
- IDLE:
  - On training_en = 1, latch gen_sel.
  - 01 or 10 → SLOS1 next cycle.
  - 00 or 11 → ERROR.
- Entering IDLE clears sticky flags, counters and the latched gen.
- Outputs are registered. os_valid = 1 in SLOS1, SLOS2, TS1 and TS2 from the first cycle in the state.
- Handshake:
  - A transfer is a cycle with os_valid & os_ready.
  - os_type and os_block_idx hold stable until the transfer.
  - The next request is presented the following cycle with no bubble, so back-to-back transfers give one per cycle.
- SLOS states:
  - os_block_idx increments on each transfer.
  - After BLOCKS-1 (31 for Gen2, 15 for Gen3) it wraps to 0 and seq_cnt increments, saturating at MIN_SLOS.
  - A state is left only on the transfer of the last block, never mid-sequence.
- Sticky flags:
  - slos1_seen is set by rx_slos1_det in SLOS1.
  - slos2_seen is set by rx_slos2_det in SLOS1 or SLOS2, since the partner may advance first.
  - ts2_seen is set by rx_ts2_det in TS1 or TS2.
  - A pulse coinciding with the deciding transfer counts in that same cycle.
- SLOS1 → SLOS2 when all hold:
  - last-block transfer;
  - seq_cnt (including this wrap) ≥ MIN_SLOS;
  - (slos1_seen | slos2_seen).
- SLOS2 → TS1 under the same rule using slos2_seen. seq_cnt and os_block_idx clear on the transition.
- TS1: ts_cnt counts transfers. → TS2 on the transfer that makes ts_cnt = TS1_CNT; ts_cnt then clears.
- TS2:
  - ts_cnt saturates at TS2_CNT.
  - → DONE on a transfer where ts_cnt ≥ TS2_CNT (including this one) and ts2_seen.
  - Otherwise keep sending TS2.
- DONE: os_valid = 0, os_type = OS_NONE, training_done = 1, held until training_en = 0.
- Watchdog:
  - The timer clears on every state change and counts each cycle in SLOS1, SLOS2, TS1 and TS2.
  - Reaching TIMEOUT_CYC → ERROR.
- ERROR: training_err = 1, os_valid = 0, held until training_en = 0.
- Abort: training_en = 0 in any state → IDLE next cycle, with all outputs at reset values. An un-accepted request is dropped; an os_ready in the abort cycle is ignored.
- rst takes priority over every event, mid-operation included.
- Detection pulses in states not listed above are ignored.

Decomposition:
- Add to the shared symbols package:
  - the os_type enum;
  - GEN2 = 2'b01 and GEN3 = 2'b10;
  - SLOS_BLOCKS_GEN2 = 32 and SLOS_BLOCKS_GEN3 = 16.
- One sub-module, training_timer: clear/enable/expired watchdog counter, parameterised by TMR_W and TIMEOUT_CYC.

Test Plan:
- Gen2, os_ready = 1, rx_slos1_det at cycle 5 → exactly 64 SLOS1 transfers (idx 0..31 twice), then SLOS2 starts at idx 0.
- Gen3, partner pulses early, os_ready = 1 → 32 SLOS1, 32 SLOS2, 16 TS1, 16 TS2; training_done = 1 the cycle after the 16th TS2.
- os_ready toggling 1/0 → os_type and os_block_idx stable while stalled; no block skipped or duplicated across wrap 31→0.
- rx_ts2_det withheld until after 40 TS2 → TS2 continues; DONE follows the first transfer after the pulse. Pulse on the 16th transfer itself → DONE immediately.
- TIMEOUT_CYC = 100, no partner detection → training_err = 1 at SLOS1 cycle 100, os_valid = 0; training_en low → IDLE, err = 0.
- training_en dropped mid-TS1 with os_valid = 1 and os_ready = 0 → next cycle all outputs at reset. gen_sel = 2'b11 → ERROR on the first cycle.
